// File: rtl/boot_loader_if.sv
// Boot loader bus: UART byte stream in, byte-laned RAM write port
// and load status out.
interface boot_loader_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  start;
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [ADDR_WIDTH-3:0] addr;
    logic [3:0]            cs_n;
    logic [3:0]            we_n;
    logic [31:0]           data_o;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [1:0]            err_code;

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, addr, cs_n, we_n, data_o,
        input  busy, done, error, err_code
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, addr, cs_n, we_n, data_o,
        output busy, done, error, err_code
    );
endinterface

// File: rtl/boot_loader.sv
// Boot loader: frames a UART byte stream (count, words, checksum) into
// little-endian 32-bit RAM writes starting at word address 0.
module boot_loader #(
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         rst_n,
    boot_loader_if.slave bus
);
    localparam int AW = ADDR_WIDTH - 2;
    localparam logic [AW:0] WORDS = {1'b1, {AW{1'b0}}};
    localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t        r_state;
    logic          r_rx_ready;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_cs_n;
    logic [3:0]    r_we_n;
    logic [31:0]   r_data;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic [1:0]    r_err_code;
    logic [7:0]    r_lo;
    logic          r_len_hi;
    logic [AW:0]   r_len;
    logic [AW:0]   r_idx;
    logic [1:0]    r_byte;
    logic [31:0]   r_word;
    logic [7:0]    r_sum;
    logic [31:0]   r_tmo;

    logic          w_acc;
    logic [15:0]   w_n;
    logic [31:0]   w_word;
    logic [AW:0]   w_idx_nx;
    logic          w_tmo;

    assign w_acc    = bus.rx_valid & r_rx_ready;
    assign w_n      = {bus.rx_data, r_lo};
    assign w_word   = {bus.rx_data, r_word[31:8]};
    assign w_idx_nx = r_idx + (AW+1)'(1);
    assign w_tmo    = (TMO != 32'd0) && (r_tmo == TMO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rx_ready <= 1'b0;
            r_addr     <= '0;
            r_cs_n     <= 4'hF;
            r_we_n     <= 4'hF;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= 2'd0;
            r_lo       <= '0;
            r_len_hi   <= 1'b0;
            r_len      <= '0;
            r_idx      <= '0;
            r_byte     <= '0;
            r_word     <= '0;
            r_sum      <= '0;
            r_tmo      <= '0;
        end else begin
            r_cs_n <= 4'hF;
            r_we_n <= 4'hF;
            unique case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        r_state    <= S_LEN;
                        r_rx_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_err_code <= 2'd0;
                        r_len_hi   <= 1'b0;
                        r_idx      <= '0;
                        r_byte     <= '0;
                        r_sum      <= '0;
                        r_tmo      <= '0;
                    end
                end
                S_LEN, S_DATA, S_CSUM: begin
                    r_tmo <= w_acc ? 32'd0 : r_tmo + 32'd1;
                    // an accepted byte beats a timeout in the same cycle
                    if (!w_acc && w_tmo) begin
                        r_state    <= S_ERR;
                        r_rx_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_error    <= 1'b1;
                        r_err_code <= 2'd3;
                    end else if (w_acc && r_state == S_LEN) begin
                        if (!r_len_hi) begin
                            r_lo     <= bus.rx_data;
                            r_len_hi <= 1'b1;
                        end else if ({1'b0, w_n} > 17'(WORDS)) begin
                            r_state    <= S_ERR;
                            r_rx_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_error    <= 1'b1;
                            r_err_code <= 2'd1;
                        end else begin
                            r_len   <= w_n[AW:0];
                            r_state <= (w_n == 16'd0) ? S_CSUM : S_DATA;
                        end
                    end else if (w_acc && r_state == S_DATA) begin
                        r_word <= w_word;
                        r_sum  <= r_sum + bus.rx_data;
                        r_byte <= r_byte + 2'd1;
                        if (r_byte == 2'd3) begin
                            r_state    <= S_WRITE;
                            r_rx_ready <= 1'b0;
                            r_cs_n     <= 4'h0;
                            r_we_n     <= 4'h0;
                            r_addr     <= r_idx[AW-1:0];
                            r_data     <= w_word;
                        end
                    end else if (w_acc) begin
                        r_rx_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        if (bus.rx_data == r_sum) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_ERR;
                            r_error    <= 1'b1;
                            r_err_code <= 2'd2;
                        end
                    end
                end
                S_WRITE: begin
                    r_idx      <= w_idx_nx;
                    r_rx_ready <= 1'b1;
                    r_state    <= (w_idx_nx == r_len) ? S_CSUM : S_DATA;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rx_ready = r_rx_ready;
    assign bus.addr     = r_addr;
    assign bus.cs_n     = r_cs_n;
    assign bus.we_n     = r_we_n;
    assign bus.data_o   = r_data;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.error    = r_error;
    assign bus.err_code = r_err_code;
endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Upstream write-side stage for the byte-laned boot RAM.
- Consumes a framed byte stream from the UART receiver: 16-bit word count, payload words, 8-bit checksum.
- Assembles 32-bit little-endian words and writes each into consecutive RAM words from word address 0, driving all four byte lanes in one strobe.
- Reports completion or error so the boot controller can release the CPU from reset or retry.

Parameters:
ADDR_WIDTH, 12, byte-address width of the target RAM; capacity is 2**(ADDR_WIDTH-2) words.
TIMEOUT_CYCLES, 1000000, max idle cycles between accepted bytes while loading; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse that begins a load
rx_data  in  8  received byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  byte accepted when rx_valid & rx_ready
addr  out  ADDR_WIDTH-2  RAM word address (RAM addr bits [ADDR_WIDTH-1:2])
cs_n  out  4  RAM byte-lane chip selects, active low
we_n  out  4  RAM byte-lane write enables, active low
data_o  out  32  RAM write data
busy  out  1  load in progress
done  out  1  load completed with good checksum
error  out  1  load aborted
err_code  out  2  1 = length overflow, 2 = checksum mismatch, 3 = timeout; 0 otherwise

Behaviour:
- Reset (async, any state): state IDLE; rx_ready=0, cs_n=4'hF, we_n=4'hF, addr=0, data_o=0, busy=0, done=0, error=0, err_code=0; internal counters and checksum cleared.
- Reset mid-load: strobes deassert immediately; RAM words already written are kept.
- States: IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR.
- start: honoured only in IDLE, DONE or ERR.
  - Clears done/error/err_code, word index, checksum and timeout counter.
  - Next state LEN; busy=1 until DONE or ERR. start while busy is ignored.
- rx_ready=1 only in LEN, DATA and CSUM. Registered: it reflects the current state, and WRITE holds it low for exactly one cycle.
- LEN: two bytes, low byte first, form the 16-bit word count N.
  - N > 2**(ADDR_WIDTH-2) -> ERR with code 1, no RAM access.
  - N == 0 -> CSUM.
  - Otherwise -> DATA.
- DATA: byte k (0..3) of the current word goes to data_o[8k+7:8k]. Each data byte is added to an 8-bit wrapping checksum. After byte 3 -> WRITE.
- WRITE: one cycle with cs_n=4'h0, we_n=4'h0, addr=current word index, data_o=assembled word.
  - Next cycle: index+1. If new index == N -> CSUM, else DATA.
  - Latency: last byte of a word accepted in cycle T -> strobe in cycle T+1.
- Strobes outside WRITE: cs_n=we_n=4'hF. The block never reads the RAM. addr and data_o hold their last values.
- CSUM: one byte compared with the running sum of data bytes only (length bytes excluded). Match -> DONE, mismatch -> ERR with code 2.
- DONE: done=1, busy=0; held until the next start or reset.
- ERR: error=1, busy=0, err_code held until the next start or reset.
- Timeout counter:
  - Cleared on entry to LEN and on every accepted byte.
  - Counts in LEN/DATA/CSUM when no byte is accepted; frozen in WRITE.
  - Reaching TIMEOUT_CYCLES -> ERR with code 3 on the next edge.
  - A byte accepted in the same cycle the limit is reached wins and clears the counter.
- Index wrap: N == 2**(ADDR_WIDTH-2) is legal. The final write uses address 2**(ADDR_WIDTH-2)-1, and the index counter is one bit wider than addr so it never aliases.
- rx_valid with rx_ready low: the byte is not consumed; the source must hold it.

Test Plan:
- Two-word load: start; bytes 02 00 78 56 34 12 EF BE AD DE 4C -> write addr0=0x12345678, then write addr1=0xDEADBEEF, each a single-cycle all-lane strobe; done=1, err_code=0, busy=0.
- Zero length: start; bytes 00 00 00 -> no strobe ever asserted; done=1.
- Bad checksum: two-word load with final byte 4D -> both writes still occur; error=1, err_code=2, done=0.
- Overflow (ADDR_WIDTH=12): start; bytes 01 04 (N=1025) -> error=1, err_code=1, rx_ready=0, no strobes. Repeat with 00 04 (N=1024): accepted, last write at addr 1023.
- Timeout (TIMEOUT_CYCLES=16): start; bytes 01 00 AA, then rx_valid=0 -> error=1, err_code=3 after 16 idle cycles, no write strobe.
- Robustness:
  - rx_valid toggling with random gaps during load -> same writes as the first test.
  - start pulsed mid-load -> ignored.
  - rst_n low during DATA -> all outputs at reset values immediately; a following start plus full frame completes with done=1.
